// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared definitions for the FPU issue controller.
//   rmode_e        : FPU rounding-mode encoding
//   fpu_op_e       : FPU operation encoding
//   cmd_payload_t  : one FPU command without its tag (the tag width is a module parameter)
//   cnt_width()    : width of a counter that must hold the value 0..depth inclusive
package fpu_issue_ctrl_pkg;

    localparam int unsigned FpWidth = 32;

    typedef enum logic [1:0] {
        RmNearest = 2'd0,
        RmZero    = 2'd1,
        RmUp      = 2'd2,
        RmDown    = 2'd3
    } rmode_e;

    typedef enum logic [2:0] {
        OpAdd = 3'd0,
        OpSub = 3'd1,
        OpMul = 3'd2,
        OpDiv = 3'd3,
        OpI2f = 3'd4,
        OpF2i = 3'd5
    } fpu_op_e;

    typedef struct packed {
        rmode_e               rmode;
        fpu_op_e              op;
        logic [FpWidth-1:0]   opa;
        logic [FpWidth-1:0]   opb;
    } cmd_payload_t;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Bundle of the command, FPU and result handshake signals of fpu_issue_ctrl.
//   slave  : controller view (accepts commands, drives the FPU, returns results)
//   master : environment view (offers commands, models the FPU, consumes results)
// Signals:
//   cmd_valid/cmd_ready, cmd_rmode, cmd_op, cmd_opa, cmd_opb, cmd_tag : command channel
//   fpu_rmode, fpu_op, fpu_opa, fpu_opb, fpu_out                       : FPU operands/result
//   res_valid/res_ready, res_data, res_tag                             : result channel
//   busy                                                               : any work outstanding
interface fpu_issue_ctrl_if
    import fpu_issue_ctrl_pkg::*;
#(
    parameter int unsigned TAG_W = 4
) ();

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_rmode;
    logic [2:0]           cmd_op;
    logic [FpWidth-1:0]   cmd_opa;
    logic [FpWidth-1:0]   cmd_opb;
    logic [TAG_W-1:0]     cmd_tag;

    logic [1:0]           fpu_rmode;
    logic [2:0]           fpu_op;
    logic [FpWidth-1:0]   fpu_opa;
    logic [FpWidth-1:0]   fpu_opb;
    logic [FpWidth-1:0]   fpu_out;

    logic                 res_valid;
    logic                 res_ready;
    logic [FpWidth-1:0]   res_data;
    logic [TAG_W-1:0]     res_tag;

    logic                 busy;

    modport slave (
        input  cmd_valid, cmd_rmode, cmd_op, cmd_opa, cmd_opb, cmd_tag,
        output cmd_ready,
        output fpu_rmode, fpu_op, fpu_opa, fpu_opb,
        input  fpu_out,
        output res_valid, res_data, res_tag,
        input  res_ready,
        output busy
    );

    modport master (
        output cmd_valid, cmd_rmode, cmd_op, cmd_opa, cmd_opb, cmd_tag,
        input  cmd_ready,
        input  fpu_rmode, fpu_op, fpu_opa, fpu_opb,
        output fpu_out,
        input  res_valid, res_data, res_tag,
        output res_ready,
        input  busy
    );

endinterface

// File: rtl/fpu_sync_fifo.sv
// Generic synchronous FIFO used for both the command and the result queue.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   push/wdata : write request; ignored when full
//   pop        : read request; ignored when empty
//   rdata      : head entry, reads 0 while empty
//   count      : number of stored entries, 0..Depth
module fpu_sync_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [Width-1:0]       wdata,
    input  logic                   pop,
    output logic [Width-1:0]       rdata,
    output logic [$clog2(Depth):0] count
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q;
    logic [PtrW-1:0]  rptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    // A push at full is dropped even with a simultaneous pop; callers gate on count.
    always_comb begin
        do_pop  = pop && (count_q != '0);
        do_push = push && (count_q != CntFull);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            // Depth is a power of two, so pointers wrap naturally.
            if (do_push) wptr_q <= wptr_q + PtrW'(1);
            if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

    assign rdata = (count_q != '0) ? mem_q[rptr_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/fpu_issue_ctrl.sv
// In-order issue controller in front of a fixed-latency FPU.
// Commands are queued in a CQ, issued one per cycle to registered FPU operand outputs,
// tracked through an FPU_LAT-deep valid/tag pipe and captured into an RQ when they exit.
// A credit count (in-flight + RQ occupancy) bounds issue so the RQ can never overflow.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   bus        : command, FPU and result signals (slave view of fpu_issue_ctrl_if)
// The interface instance must use the same TAG_W as this module.
module fpu_issue_ctrl
    import fpu_issue_ctrl_pkg::*;
#(
    parameter int unsigned CQ_DEPTH = 4,
    parameter int unsigned RQ_DEPTH = 4,
    parameter int unsigned FPU_LAT  = 4,
    parameter int unsigned TAG_W    = 4
) (
    input logic             clk,
    input logic             reset,
    fpu_issue_ctrl_if.slave bus
);

    localparam int unsigned CmdW   = $bits(cmd_payload_t) + TAG_W;
    localparam int unsigned RqW    = FpWidth + TAG_W;
    localparam int unsigned CqCntW = cnt_width(CQ_DEPTH);
    localparam int unsigned RqCntW = cnt_width(RQ_DEPTH);
    localparam logic [CqCntW-1:0] CqFull    = CqCntW'(CQ_DEPTH);
    localparam logic [RqCntW-1:0] CreditMax = RqCntW'(RQ_DEPTH);

    // Command queue
    cmd_payload_t       cmd_in;
    cmd_payload_t       cq_head;
    logic [TAG_W-1:0]   cq_head_tag;
    logic [CmdW-1:0]    cq_wdata;
    logic [CmdW-1:0]    cq_rdata;
    logic [CqCntW-1:0]  cq_count;
    logic               cq_empty;
    logic               cq_push;

    // Issue, pipe tracking and credits
    logic               issue;
    cmd_payload_t       fpu_q;
    logic [FPU_LAT-1:0] vld_q;
    logic [TAG_W-1:0]   ptag_q [FPU_LAT];
    logic [RqCntW-1:0]  credit_q;

    // Result queue
    logic               rq_push;
    logic               rq_pop;
    logic [RqW-1:0]     rq_wdata;
    logic [RqW-1:0]     rq_rdata;
    logic [RqCntW-1:0]  rq_count;

    always_comb begin
        cmd_in.rmode = rmode_e'(bus.cmd_rmode);
        cmd_in.op    = fpu_op_e'(bus.cmd_op);
        cmd_in.opa   = bus.cmd_opa;
        cmd_in.opb   = bus.cmd_opb;
    end

    assign cq_wdata               = {cmd_in, bus.cmd_tag};
    assign {cq_head, cq_head_tag} = cq_rdata;
    assign cq_empty               = (cq_count == '0);

    // Ready depends only on registered occupancy, never on cmd_valid or issue.
    assign bus.cmd_ready = (cq_count != CqFull);
    assign cq_push       = bus.cmd_valid && bus.cmd_ready;

    fpu_sync_fifo #(
        .Width (CmdW),
        .Depth (CQ_DEPTH)
    ) u_cq (
        .clk   (clk),
        .reset (reset),
        .push  (cq_push),
        .wdata (cq_wdata),
        .pop   (issue),
        .rdata (cq_rdata),
        .count (cq_count)
    );

    // Credit uses register values only; a same-edge RQ pop frees its slot a cycle later.
    assign issue = !cq_empty && (credit_q < CreditMax);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpu_q    <= '0;
            vld_q    <= '0;
            credit_q <= '0;
            for (int i = 0; i < FPU_LAT; i++) ptag_q[i] <= '0;
        end else begin
            if (issue) fpu_q <= cq_head;
            vld_q[0]  <= issue;
            ptag_q[0] <= cq_head_tag;
            for (int i = 1; i < FPU_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                ptag_q[i] <= ptag_q[i-1];
            end
            credit_q <= credit_q + RqCntW'(issue) - RqCntW'(rq_pop);
        end
    end

    assign bus.fpu_rmode = fpu_q.rmode;
    assign bus.fpu_op    = fpu_q.op;
    assign bus.fpu_opa   = fpu_q.opa;
    assign bus.fpu_opb   = fpu_q.opb;

    // The slot leaving the pipe this edge carries the FPU result sampled on the same edge.
    assign rq_push  = vld_q[FPU_LAT-1];
    assign rq_wdata = {bus.fpu_out, ptag_q[FPU_LAT-1]};
    assign rq_pop   = bus.res_valid && bus.res_ready;

    fpu_sync_fifo #(
        .Width (RqW),
        .Depth (RQ_DEPTH)
    ) u_rq (
        .clk   (clk),
        .reset (reset),
        .push  (rq_push),
        .wdata (rq_wdata),
        .pop   (rq_pop),
        .rdata (rq_rdata),
        .count (rq_count)
    );

    assign bus.res_valid               = (rq_count != '0);
    assign {bus.res_data, bus.res_tag} = rq_rdata;
    assign bus.busy                    = !cq_empty || (|vld_q) || bus.res_valid;

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- CQ_DEPTH, 4, command queue entries (power of 2, >=2).
- RQ_DEPTH, 4, result queue entries (power of 2, >=2).
- FPU_LAT, 4, cycles from registered FPU operand update to valid fpu_out.
- TAG_W, 4, width of the request tag.
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid is also high.
- cmd_rmode  in  2  rounding mode.
- cmd_op  in  3  FPU operation.
- cmd_opa  in  32  operand A, IEEE-754 single.
- cmd_opb  in  32  operand B, IEEE-754 single.
- cmd_tag  in  TAG_W  request identifier.
- fpu_rmode  out  2  to FPU rounding mode.
- fpu_op  out  3  to FPU operation.
- fpu_opa  out  32  to FPU operand A.
- fpu_opb  out  32  to FPU operand B.
- fpu_out  in  32  FPU result.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed when res_valid is also high.
- res_data  out  32  result value.
- res_tag  out  TAG_W  tag of the command that produced res_data.
- busy  out  1  high while any command is queued, in flight or unread.
REQ-003 SHALL use one clock; reset SHALL be asynchronous and active-high; ports SHALL be named clk and reset.

Function
REQ-004 SHALL buffer accepted commands {rmode, op, opa, opb, tag} in an in-order CQ_DEPTH FIFO.
REQ-005 SHALL drive cmd_ready = (CQ count < CQ_DEPTH); cmd_ready SHALL NOT depend combinationally on cmd_valid or on the issue decision.
REQ-006 SHALL issue the CQ head on a clock edge only when CQ is non-empty AND inflight + rq_count < RQ_DEPTH (credit rule); exactly one command per edge at most.
REQ-007 On issue, fpu_rmode/fpu_op/fpu_opa/fpu_opb SHALL be registered from the CQ head; with no issue they SHALL hold their last values.
REQ-008 SHALL track issues with a FPU_LAT-deep valid+tag shift register; when a slot exits, fpu_out and its tag SHALL be pushed into the RQ on that edge.
REQ-009 The minimum latency from the accepting edge to res_valid high SHALL be FPU_LAT+1 cycles; back-to-back issue SHALL sustain one result per cycle while res_ready stays high.
REQ-010 Results SHALL be returned strictly in acceptance order.
REQ-011 res_valid = RQ non-empty; res_data/res_tag = RQ head; these SHALL stay stable while res_valid=1 and res_ready=0.
REQ-012 Simultaneous CQ push and pop SHALL be legal at any count except full, where no push occurs. Simultaneous RQ push and pop SHALL be legal at any count, including full-minus-credit.
REQ-013 The credit rule SHALL guarantee that an RQ push never finds the RQ full; no result SHALL be dropped.
REQ-014 busy = CQ non-empty OR any in-flight valid OR RQ non-empty.
REQ-015 Pointers SHALL wrap modulo depth; counts SHALL be sized to represent the full depth value.

Reset
REQ-016 Reset SHALL clear CQ/RQ pointers and counts, all in-flight valids and the credit count; cmd_ready=1, res_valid=0, busy=0.
REQ-017 fpu_rmode, fpu_op, fpu_opa and fpu_opb SHALL reset to 0; res_data and res_tag SHALL read 0.
REQ-018 Reset asserted mid-operation SHALL discard all queued and in-flight work; no stale result SHALL appear after release.

Structure
REQ-019 rmode/op enumerations and the command struct type SHALL live in the shared definitions package; TAG_W and the FIFO depths SHALL remain module parameters.
REQ-020 Both queues SHALL instantiate one generic sub-module, fpu_sync_fifo (parameterised width/depth, count output).

Verification
REQ-021 Single MULT with round_up, opa=0x3F800000 and opb=0x40000000, tag=3, res_ready=1 -> res_valid rises FPU_LAT+1 cycles after acceptance, res_data=0x40000000, res_tag=3.
REQ-022 Four back-to-back ADD/SUB/MULT/DIV with tags 0..3 and res_ready=1 -> results arrive on consecutive cycles with tags 0,1,2,3.
REQ-023 res_ready=0 while 10 commands are offered -> 4 results are held, the CQ fills, cmd_ready=0, and issue stalls by credit; releasing res_ready drains all 10 in order with none lost.
REQ-024 res_ready toggled every cycle during a stream -> RQ push and pop occur on the same edge, with no overflow and no duplicated result.
REQ-025 Reset asserted with 2 queued and 2 in-flight commands -> after release, res_valid=0, busy=0 and the fpu_* outputs are 0; a fresh command completes normally.
